// File: rtl/d_sram_to_sram_like_pkg.sv
// Shared encodings for the data-side SRAM to sram-like adapter.
package d_sram_to_sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/d_sram_to_sram_like_if.sv
// sram-like request/handshake bus between the adapter (master) and the AXI bridge (slave).
interface d_sram_to_sram_like_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/d_sram_to_sram_like.sv
// Turns one memory-stage SRAM-style access into a single sram-like transaction and
// holds the returned data until the pipeline releases its longest stall.
module d_sram_to_sram_like
  import d_sram_to_sram_like_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  d_sram_to_sram_like_if.master bus
);

  // Unusual masks (e.g. 0110) fall back to a word access.
  function automatic logic [1:0] mask_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Next-state and request-field computation.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (data_sram_en) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wr_d    = |data_sram_wen;
          wdata_d = data_sram_wdata;
          if (|data_sram_wen) begin
            size_d = mask_to_size(data_sram_wen);
            addr_d = data_sram_addr;
          end else begin
            size_d = SIZE_WORD;
            addr_d = {data_sram_addr[ADDR_W-1:2], 2'b00};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // Request stays up until accepted, even if the core withdraws data_sram_en.
      S_REQ: begin
        if (bus.data_addr_ok) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end else begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          state_d = S_DONE;
          if (!wr_q) begin
            rdata_d = bus.data_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (!longest_stall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall is combinational so the hazard unit sees it in the enable cycle itself.
  always_comb begin
    d_stall = 1'b0;
    case (state_q)
      S_IDLE:  d_stall = data_sram_en;
      S_REQ:   d_stall = 1'b1;
      S_WAIT:  d_stall = 1'b1;
      S_DONE:  d_stall = 1'b0;
      default: d_stall = 1'b0;
    endcase
  end

  assign bus.data_req     = req_q;
  assign bus.data_wr      = wr_q;
  assign bus.data_size    = size_q;
  assign bus.data_addr    = addr_q;
  assign bus.data_wdata   = wdata_q;
  assign data_sram_rdata  = rdata_q;

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed and randomized bench for d_sram_to_sram_like with a bus-level reference model.
module tb_d_sram_to_sram_like;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [3:0]    wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] sram_rdata;
  logic          d_stall;
  logic          longest_stall;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_rdata;

  always #5 clk = ~clk;

  d_sram_to_sram_like_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  d_sram_to_sram_like #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .bus             (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access size from the byte-mask rules: reads and full masks are words.
  function automatic logic [1:0] ref_size(input logic [3:0] m);
    if (m == 4'd0 || m == 4'hF) return 2'd2;
    if (m == 4'h3 || m == 4'hC) return 2'd1;
    if ($countones(m) == 1)     return 2'd0;
    return 2'd2;
  endfunction

  // One complete access: enable, request held ok_dly extra cycles, data_ok after
  // dok_dly WAIT cycles, then stall_cyc cycles of global stall before release.
  task automatic access(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input int ok_dly, input int dok_dly, input logic [31:0] rd,
                        input int stall_cyc, input bit drop_en);
    bit          is_wr;
    logic [31:0] ea;
    logic [1:0]  es;
    is_wr = (m != 4'd0);
    ea    = is_wr ? a : (a & 32'hFFFF_FFFC);
    es    = ref_size(m);
    en = 1'b1; wen = m; addr = a; wdata = wd; longest_stall = 1'b0;
    #1;
    check("stall_en_cycle", d_stall, 1);
    check("req_en_cycle", bus.data_req, 0);
    step();
    for (int i = 0; i <= ok_dly; i++) begin
      if (drop_en) en = 1'b0;
      check("req_high", bus.data_req, 1);
      check("req_wr", bus.data_wr, is_wr);
      check("req_size", bus.data_size, es);
      check("req_addr", bus.data_addr, ea);
      check("req_wdata", bus.data_wdata, wd);
      check("stall_req", d_stall, 1);
      if (i == ok_dly) begin
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
      end else begin
        // Stray data_ok before acceptance must be ignored.
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = ~rd;
      end
      step();
    end
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    for (int i = 0; i < dok_dly; i++) begin
      check("req_low_wait", bus.data_req, 0);
      check("stall_wait", d_stall, 1);
      step();
    end
    check("req_low_dok", bus.data_req, 0);
    check("stall_dok", d_stall, 1);
    bus.data_data_ok = 1'b1; bus.data_rdata = rd;
    step();
    bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
    if (!is_wr) exp_rdata = rd;
    for (int k = 0; k < stall_cyc; k++) begin
      longest_stall = 1'b1;
      #1;
      check("done_stall_low", d_stall, 0);
      check("done_no_reissue", bus.data_req, 0);
      check("done_rdata", sram_rdata, exp_rdata);
      step();
    end
    longest_stall = 1'b0;
    #1;
    check("release_stall_low", d_stall, 0);
    check("release_rdata", sram_rdata, exp_rdata);
    en = 1'b0;
    step();
    check("idle_req_low", bus.data_req, 0);
    check("idle_stall_low", d_stall, 0);
    check("idle_rdata", sram_rdata, exp_rdata);
  endtask

  initial begin
    logic [3:0] m;
    rst = 1'b1; en = 1'b0; wen = 4'd0; addr = '0; wdata = '0; longest_stall = 1'b0;
    bus.data_rdata = '0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    exp_rdata = '0;
    #12;
    check("rst_req", bus.data_req, 0);
    check("rst_wr", bus.data_wr, 0);
    check("rst_size", bus.data_size, 0);
    check("rst_addr", bus.data_addr, 0);
    check("rst_wdata", bus.data_wdata, 0);
    check("rst_rdata", sram_rdata, 0);
    check("rst_stall", d_stall, 0);
    rst = 1'b0;
    step();

    access(4'b0000, 32'h8000_1006, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 0, 1'b0);
    access(4'b0100, 32'h8000_2002, 32'h00AB_0000, 3, 1, 32'h5555_AAAA, 0, 1'b0);
    access(4'b1100, 32'h8000_3002, 32'hCAFE_0000, 0, 0, 32'h0, 0, 1'b0);
    access(4'b1111, 32'h8000_4000, 32'h0BAD_F00D, 1, 2, 32'h0, 0, 1'b0);
    access(4'b0110, 32'h8000_5001, 32'h00FF_FF00, 0, 0, 32'h0, 0, 1'b0);
    access(4'b0000, 32'h8000_6003, 32'h0, 0, 0, 32'h1357_9BDF, 5, 1'b0);
    access(4'b0000, 32'h8000_7008, 32'h0, 2, 1, 32'h2468_ACE0, 1, 1'b1);

    // Asynchronous reset while WAITing for data_ok.
    en = 1'b1; wen = 4'd0; addr = 32'h8000_8000;
    step();
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    check("pre_rst_wait_stall", d_stall, 1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", bus.data_req, 0);
    check("mid_rst_wr", bus.data_wr, 0);
    check("mid_rst_size", bus.data_size, 0);
    check("mid_rst_addr", bus.data_addr, 0);
    check("mid_rst_rdata", sram_rdata, 0);
    check("mid_rst_stall", d_stall, 0);
    exp_rdata = '0;
    #1 rst = 1'b0;
    step();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_0000;
    step();
    bus.data_data_ok = 1'b0;
    check("late_dok_rdata", sram_rdata, 0);
    check("late_dok_stall", d_stall, 0);
    check("late_dok_req", bus.data_req, 0);
    access(4'b0000, 32'h8000_9004, 32'h0, 1, 0, 32'h7777_1111, 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      m = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      access(m, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
